// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1 UART receiver (1 start bit, 8 data bits LSB first, 1 stop bit)
//
// The asynchronous RXD line is brought into the Clk domain through a 2-flop
// synchronizer and every bit is sampled once near its middle using a period
// counter. Received bytes are offered to the controller on a level/ack
// interface.
//
// Handshake: Data_ready is a level that means "Data holds an unread byte".
// Data is stable for as long as Data_ready is high. The controller pulses Ack
// to consume the byte, and Data_ready drops on the following edge. If a new
// good byte completes in the same cycle as Ack, the new byte is loaded and
// Data_ready stays high. If a good byte completes while Data_ready is high and
// there is no Ack, the new byte is dropped and Overrun pulses.
//
// Parameters:
//   FREQ_CLK    system clock frequency in Hz
//   RX_SPEED    baud rate in bit/s
//
// Ports:
//   Clk         system clock, rising edge
//   Rst         asynchronous, active-high reset
//   RXD         serial line, asynchronous to Clk, idles high
//   Ack         controller consumed Data
//   Data        last good received byte
//   Data_ready  unread byte available (level)
//   Frame_err   1-cycle pulse: stop bit sampled low
//   Overrun     1-cycle pulse: good byte lost because Data_ready was still set
//   Busy        receiver is not idle
//
// The FSM state is held in the internal signal 'state' (type state_t) so that
// checkers can bind to it directly.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter logic [31:0] FREQ_CLK = 32'd100000000,
    parameter logic [31:0] RX_SPEED = 32'd115200
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RXD,
    input  logic       Ack,
    output logic [7:0] Data,
    output logic       Data_ready,
    output logic       Frame_err,
    output logic       Overrun,
    output logic       Busy
);

    // Same bit timing as the transmitter, so both ends agree on bit length.
    localparam logic [31:0] BIT_CYCLES  = FREQ_CLK / RX_SPEED + 32'd1;
    localparam logic [31:0] HALF_CYCLES = BIT_CYCLES / 32'd2;
    localparam logic [31:0] BIT_LAST    = BIT_CYCLES - 32'd1;
    localparam logic [31:0] HALF_LAST   = HALF_CYCLES - 32'd1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        RECV_DATA  = 3'd2,
        STOP_BIT   = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rxd_meta;
    logic        rxd_s;
    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        byte_done;
    logic        sample_shift;
    logic        sample_good;
    logic        sample_bad;

    // Synchronizer flops reset high so leaving reset never looks like a
    // start bit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_s    <= rxd_meta;
        end
    end

    // Next-state logic and sampling strobes.
    always_comb begin
        state_next   = state;
        sample_shift = 1'b0;
        sample_good  = 1'b0;
        sample_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) state_next = START_BIT;
            end
            START_BIT: begin
                // Re-check the line in the middle of the start bit; a high
                // level here means the falling edge was a glitch.
                if (cnt == HALF_LAST) state_next = rxd_s ? IDLE : RECV_DATA;
            end
            RECV_DATA: begin
                if (cnt == BIT_LAST) begin
                    sample_shift = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (cnt == BIT_LAST) begin
                    if (rxd_s) begin
                        sample_good = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        sample_bad = 1'b1;
                        state_next = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                // A line held low (break) must go high before a new start
                // bit can be recognised.
                if (rxd_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, period counter, bit index and shift register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            state <= state_next;

            // The counter restarts on every transition and after each data
            // sample, so every data bit is measured from the previous sample.
            if (state_next != state || sample_shift) cnt <= 32'd0;
            else if (state != IDLE)                  cnt <= cnt + 32'd1;

            if (state_next != state) bit_idx <= 3'd0;
            else if (sample_shift)   bit_idx <= bit_idx + 3'd1;

            // LSB arrives first: after 8 right shifts it sits in bit 0.
            if (sample_shift) shift_reg <= {rxd_s, shift_reg[7:1]};
        end
    end

    // Output stage: byte_done marks the stop-bit sample, the controller
    // interface updates on the edge after it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            byte_done  <= 1'b0;
            Frame_err  <= 1'b0;
            Overrun    <= 1'b0;
            Data       <= 8'd0;
            Data_ready <= 1'b0;
        end else begin
            byte_done <= sample_good;
            Frame_err <= sample_bad;
            Overrun   <= 1'b0;
            if (byte_done && (!Data_ready || Ack)) begin
                Data       <= shift_reg;
                Data_ready <= 1'b1;
            end else if (byte_done) begin
                Overrun <= 1'b1;
            end else if (Ack) begin
                Data_ready <= 1'b0;
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx at FREQ_CLK=100, RX_SPEED=10
// (11 clocks per bit, 5 clocks half-bit).
//
// The driver serialises frames onto RXD and feeds a frame-level model that
// decides what the controller should see (byte delivered, overrun or framing
// error). Expected bytes go into exp_q; the monitor pops them whenever the
// DUT presents a new byte and also acts as the controller by driving Ack.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BITC    = 11;
    // Data_ready rises 107 edges after the edge that captures the falling
    // start edge; that edge is one after the edge where the bench drove it.
    localparam int LAT_REF = 108;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       RXD = 1'b1;
    logic       Ack = 1'b0;
    logic [7:0] Data;
    logic       Data_ready;
    logic       Frame_err;
    logic       Overrun;
    logic       Busy;

    uart_rx #(
        .FREQ_CLK(32'd100),
        .RX_SPEED(32'd10)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RXD       (RXD),
        .Ack       (Ack),
        .Data      (Data),
        .Data_ready(Data_ready),
        .Frame_err (Frame_err),
        .Overrun   (Overrun),
        .Busy      (Busy)
    );

    // ---------------- clock / reset-independent cycle count ----------------
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int  vectors       = 0;
    int  miscompares   = 0;
    int  exp_fe        = 0;
    int  exp_ov        = 0;
    int  fe_seen       = 0;
    int  ov_seen       = 0;
    bit  auto_ack      = 1'b1;
    bit  pending       = 1'b0;
    int  ack_force_cyc = -1;
    int  last_start    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        RXD = v;
        step(BITC);
    endtask

    // Frame-level reference: what the controller must observe for one frame.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit force_ack);
        if (!stop_ok) begin
            exp_fe++;
        end else if (auto_ack || !pending || force_ack) begin
            exp_q.push_back(b);
            pending = !auto_ack;
        end else begin
            exp_ov++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit force_ack);
        logic [7:0] bits;
        bits = b;
        model_frame(b, stop_ok, force_ack);
        last_start = cyc;
        // Ack high on the edge where the byte reaches the output register.
        if (force_ack) ack_force_cyc = cyc + LAT_REF - 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(bits[i]);
        drive_bit(stop_ok);
    endtask

    // ---------------- monitor / controller ----------------
    initial begin
        logic       dr_prev;
        logic [7:0] want_b;
        dr_prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (Frame_err) fe_seen++;
            if (Overrun)   ov_seen++;
            // A new byte: Data_ready rose, or it stayed high across an Ack
            // (an Ack alone would have cleared it).
            if (!Rst && Data_ready && (!dr_prev || Ack)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte (cycle %0d)", Data, cyc);
                end else begin
                    want_b = exp_q.pop_front();
                    chk("rx_data", Data, want_b);
                    chk("latency", cyc - last_start, LAT_REF);
                end
            end
            dr_prev = Data_ready;
            Ack = (auto_ack && Data_ready) || (cyc == ack_force_cyc);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int fe0;
        int ov0;
        int busy_cnt;
        logic [7:0] part;
        logic [7:0] rb;
        bit ok;

        Rst = 1'b1;
        RXD = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_data", Data, 8'h00);
        chk("reset_ready", Data_ready, 1'b0);
        chk("reset_ferr", Frame_err, 1'b0);
        chk("reset_ovr", Overrun, 1'b0);
        chk("reset_busy", Busy, 1'b0);
        Rst = 1'b0;
        step(5);

        // Single frame, acknowledged by the monitor.
        send_frame(8'hA5, 1'b1, 1'b0);
        step(5);
        chk("t1_ready_cleared", Data_ready, 1'b0);
        chk("t1_data_held", Data, 8'hA5);

        // Short low glitch on an idle line.
        busy_cnt = 0;
        RXD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            if (Busy) busy_cnt++;
        end
        RXD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (Busy) busy_cnt++;
        end
        chk("t2_busy_seen", (busy_cnt >= 3 && busy_cnt <= 9), 1'b1);
        chk("t2_busy_end", Busy, 1'b0);
        chk("t2_ready", Data_ready, 1'b0);

        // Bad stop bit followed by a held-low line.
        fe0 = fe_seen;
        send_frame(8'h3C, 1'b0, 1'b0);
        step(50);
        chk("t3_busy_in_break", Busy, 1'b1);
        chk("t3_ready", Data_ready, 1'b0);
        chk("t3_ferr_pulses", fe_seen - fe0, 1);
        RXD = 1'b1;
        step(4);
        chk("t3_busy_released", Busy, 1'b0);

        // Overrun, then Ack in the completion cycle.
        auto_ack = 1'b0;
        pending  = 1'b0;
        ov0 = ov_seen;
        send_frame(8'h11, 1'b1, 1'b0);
        step(2);
        send_frame(8'h22, 1'b1, 1'b0);
        step(2);
        chk("t4_data_kept", Data, 8'h11);
        chk("t4_ready_kept", Data_ready, 1'b1);
        chk("t4_overrun", ov_seen - ov0, 1);
        send_frame(8'h22, 1'b1, 1'b1);
        step(2);
        chk("t4_data_replaced", Data, 8'h22);
        chk("t4_no_new_overrun", ov_seen - ov0, 1);
        auto_ack = 1'b1;
        pending  = 1'b0;
        step(5);
        chk("t4_ready_cleared", Data_ready, 1'b0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        step(5);

        // Reset in the middle of data bit 4, with an unread byte pending.
        auto_ack = 1'b0;
        pending  = 1'b0;
        send_frame(8'h6B, 1'b1, 1'b0);
        step(2);
        part = 8'h5A;
        RXD = 1'b0;
        step(BITC);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        RXD = part[4];
        step(5);
        #1;
        Rst = 1'b1;
        #1;
        chk("t6_data_async", Data, 8'h00);
        chk("t6_ready_async", Data_ready, 1'b0);
        chk("t6_busy_async", Busy, 1'b0);
        chk("t6_ferr_async", Frame_err, 1'b0);
        chk("t6_ovr_async", Overrun, 1'b0);
        RXD = 1'b1;
        step(3);
        Rst = 1'b0;
        step(5);
        auto_ack = 1'b1;
        pending  = 1'b0;
        send_frame(8'h81, 1'b1, 1'b0);
        step(5);

        // Random frames with occasional framing errors and random gaps.
        for (int n = 0; n < 14; n++) begin
            rb = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 99) < 80);
            send_frame(rb, ok, 1'b0);
            if (!ok) begin
                RXD = 1'b1;
                step($urandom_range(3, 12));
            end else begin
                step($urandom_range(0, 10));
            end
        end

        RXD = 1'b1;
        step(150);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_err_total", fe_seen, exp_fe);
        chk("overrun_total", ov_seen, exp_ov);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
